// File: rtl/display_pkg.sv
// Shared types and default constants for the display snapshot controller.
package display_pkg;

   typedef enum logic {DISP_RUN, DISP_HOLD} disp_state_t;

   localparam int NUM_DIGITS       = 6;
   localparam int DEF_TICK_DIV     = 5000000;
   localparam int DEF_DEBOUNCE_CYC = 500000;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer with a one-cycle press event.
// Reusable for any active-low KEY input.
module key_debounce
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);

   localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DW-1:0] C_LAST = DW'(DEBOUNCE_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [DW-1:0] r_cnt;
   logic          w_differ;
   logic          w_accept;

   assign w_differ = (r_sync2 != r_level);
   assign w_accept = w_differ && (r_cnt == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 1'b1;
         r_cnt   <= '0;
      end else if (!w_differ) begin
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_level <= r_sync2;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Press fires on the edge where the level is about to fall
   assign o_level = r_level;
   assign o_press = w_accept & ~r_sync2;

endmodule

// File: rtl/display_snapshot_ctrl.sv
// Samples the core value at a slow rate and freezes it on a key press.
// Define DISPLAY_LZB_EN for leading-zero blanking on the hex digits.
module display_snapshot_ctrl
   import display_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             value_i,
   input  logic                    hold_key_n,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [NUM_DIGITS-1:0]   blank_o,
   output logic [9:0]              leds_o,
   output logic                    hold_o,
   output logic                    update_o
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] r_tick_cnt;
   logic          w_tick;
   disp_state_t   r_state;
   disp_state_t   w_state_nxt;
   logic          w_load;
   logic          w_press;
   logic          w_unused_level;
   logic          w_unused_hi;
   logic [31:0]   r_snap;
   logic          r_update;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key_n (hold_key_n),
      .o_level (w_unused_level),
      .o_press (w_press)
   );

   assign w_tick = (r_tick_cnt == T_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tick_cnt <= '0;
      else if (w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= DISP_RUN;
      else
         r_state <= w_state_nxt;
   end

   // Sampling looks at the current state, so a press on a tick still captures
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         DISP_RUN: begin
            w_load = w_tick;
            if (w_press)
               w_state_nxt = DISP_HOLD;
         end
         DISP_HOLD: begin
            if (w_press)
               w_state_nxt = DISP_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap   <= '0;
         r_update <= 1'b0;
      end else begin
         r_update <= w_load;
         if (w_load)
            r_snap <= value_i;
      end
   end

   assign digits_o    = r_snap[4*NUM_DIGITS-1:0];
   assign leds_o      = r_snap[9:0];
   assign hold_o      = (r_state == DISP_HOLD);
   assign update_o    = r_update;
   assign w_unused_hi = ^r_snap[31:24];

`ifdef DISPLAY_LZB_EN
   logic [NUM_DIGITS-1:0] w_blank;
   logic                  w_zero_run;

   // Digit 0 always shows so a zero value reads as "0"
   always_comb begin
      w_blank    = '0;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_zero_run = w_zero_run & (r_snap[4*i +: 4] == 4'h0);
         w_blank[i] = w_zero_run;
      end
   end

   assign blank_o = w_blank;
`else
   assign blank_o = '0;
`endif

endmodule

// File: tb/tb_display_snapshot_ctrl.sv
// Randomised self-checking bench for display_snapshot_ctrl.
// Small TICK_DIV/DEBOUNCE_CYC keep the run short.
module tb_display_snapshot_ctrl;

   localparam int TD = 4;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] value_i = '0;
   logic        hold_key_n = 1'b1;
   logic [23:0] digits_o;
   logic [5:0]  blank_o;
   logic [9:0]  leds_o;
   logic        hold_o;
   logic        update_o;

   display_snapshot_ctrl #(
      .TICK_DIV     (TD),
      .DEBOUNCE_CYC (DB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_i    (value_i),
      .hold_key_n (hold_key_n),
      .digits_o   (digits_o),
      .blank_o    (blank_o),
      .leds_o     (leds_o),
      .hold_o     (hold_o),
      .update_o   (update_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          m_cyc;
   logic        m_s1, m_s2, m_db;
   int          m_run;
   logic        m_hold;
   logic [31:0] m_snap;
   logic        m_upd;

   function automatic logic [5:0] exp_blank(input logic [31:0] s);
      logic [5:0] b;
      b = '0;
`ifdef DISPLAY_LZB_EN
      for (int i = 1; i < 6; i++)
         b[i] = ((s[23:0] >> (4*i)) == 24'd0);
`endif
      return b;
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0;
      m_hold = 0; m_snap = '0; m_upd = 0;
   endtask

   // Advance one clock and update the model with the pre-edge inputs
   task automatic cycle();
      logic ks, tick, press, load;
      @(posedge clk);
      ks    = m_s2;
      tick  = ((m_cyc % TD) == TD - 1);
      press = 0;
      if (ks == m_db) m_run = 0;
      else if (m_run + 1 >= DB) begin
         press = !ks; m_db = ks; m_run = 0;
      end else m_run++;
      load  = tick && !m_hold;
      m_upd = load;
      if (load) m_snap = value_i;
      if (press) m_hold = !m_hold;
      m_s2 = m_s1; m_s1 = hold_key_n; m_cyc++;
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #3;
      total++;
      if ({hold_o, update_o, digits_o, leds_o} !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%h exp=0", {hold_o, update_o, digits_o, leds_o});
      end
      total++;
      if (blank_o !== exp_blank(32'h0)) begin
         bad++;
         $display("FAIL reset_blank got=%b exp=%b", blank_o, exp_blank(32'h0));
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_snapshot();
      logic exp_u;
      value_i = 32'h00123456;
      for (int i = 0; i < 13; i++) begin
         cycle();
         total++;
         if ({hold_o, update_o, digits_o, leds_o, blank_o} !==
             {m_hold, m_upd, m_snap[23:0], m_snap[9:0], exp_blank(m_snap)}) begin
            bad++;
            $display("FAIL snap_model c=%0d got=%h/%b exp=%h/%b", m_cyc,
                     digits_o, update_o, m_snap[23:0], m_upd);
         end
         exp_u = (m_cyc >= 4) && (m_cyc % 4 == 0);
         total++;
         if (update_o !== exp_u) begin
            bad++;
            $display("FAIL snap_update c=%0d got=%b exp=%b", m_cyc, update_o, exp_u);
         end
         if (m_cyc == 4) begin
            total++;
            if (digits_o !== 24'h123456 || leds_o !== 10'h056) begin
               bad++;
               $display("FAIL snap_first got=%h/%h exp=123456/056", digits_o, leds_o);
            end
         end
      end
   endtask

   task automatic test_press();
      int rises = 0, rise_at = -1;
      logic prev;
      prev = hold_o;
      hold_key_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (hold_o && !prev) begin rises++; rise_at = i; end
         prev = hold_o;
         total++;
         if ({hold_o, update_o, digits_o} !== {m_hold, m_upd, m_snap[23:0]}) begin
            bad++;
            $display("FAIL press_model i=%0d got=%b/%h exp=%b/%h", i, hold_o, digits_o,
                     m_hold, m_snap[23:0]);
         end
      end
      total++;
      if (rises !== 1 || rise_at !== 4) begin
         bad++;
         $display("FAIL press_rise got=%0d@%0d exp=1@4", rises, rise_at);
      end
      hold_key_n = 1'b1;
      value_i = 32'hFFFFFFFF;
      for (int i = 0; i < 12; i++) begin
         cycle();
         total++;
         if (digits_o !== 24'h123456 || update_o !== 1'b0 || hold_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_frozen i=%0d got=%h/%b/%b exp=123456/0/1", i,
                     digits_o, update_o, hold_o);
         end
      end
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 12; i++) begin
         hold_key_n = (i < 2) ? 1'b0 : 1'b1;
         cycle();
         total++;
         if ({hold_o, update_o, digits_o} !== {m_hold, m_upd, m_snap[23:0]} ||
             hold_o !== 1'b1) begin
            bad++;
            $display("FAIL glitch i=%0d got=%b exp=1", i, hold_o);
         end
      end
   endtask

   task automatic test_second_press();
      int ups = 0;
      for (int i = 0; i < 18; i++) begin
         hold_key_n = (i < 8) ? 1'b0 : 1'b1;
         cycle();
         if (update_o) ups++;
         total++;
         if ({hold_o, update_o, digits_o, leds_o} !==
             {m_hold, m_upd, m_snap[23:0], m_snap[9:0]}) begin
            bad++;
            $display("FAIL press2_model i=%0d got=%b/%b/%h exp=%b/%b/%h", i, hold_o,
                     update_o, digits_o, m_hold, m_upd, m_snap[23:0]);
         end
      end
      total++;
      if (hold_o !== 1'b0 || digits_o !== 24'hFFFFFF || leds_o !== 10'h3FF || ups == 0) begin
         bad++;
         $display("FAIL press2_resume got=%b/%h/%h ups=%0d exp=0/FFFFFF/3FF ups>0",
                  hold_o, digits_o, leds_o, ups);
      end
   endtask

   task automatic test_press_on_tick();
      logic [31:0] v;
      for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) cycle();
      v = $urandom;
      value_i = v;
      hold_key_n = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      total++;
      if (hold_o !== 1'b1 || update_o !== 1'b1 || digits_o !== v[23:0]) begin
         bad++;
         $display("FAIL press_on_tick got=%b/%b/%h exp=1/1/%h", hold_o, update_o,
                  digits_o, v[23:0]);
      end
      hold_key_n = 1'b1;
      value_i = ~v;
      for (int i = 0; i < 8; i++) begin
         cycle();
         total++;
         if ({hold_o, update_o, digits_o} !== {m_hold, m_upd, m_snap[23:0]} ||
             digits_o !== v[23:0]) begin
            bad++;
            $display("FAIL tick_hold i=%0d got=%h exp=%h", i, digits_o, v[23:0]);
         end
      end
   endtask

   task automatic test_async_reset();
      total++;
      if (hold_o !== 1'b1) begin
         bad++;
         $display("FAIL arst_pre got=%b exp=1", hold_o);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      total++;
      if ({hold_o, update_o, digits_o, leds_o} !== '0 || blank_o !== exp_blank(32'h0)) begin
         bad++;
         $display("FAIL arst_now got=%h/%b exp=0", {hold_o, update_o, digits_o, leds_o},
                  blank_o);
      end
      @(negedge clk) rst_n = 1'b1;
      value_i = 32'h00ABCDEF;
      for (int i = 0; i < 9; i++) begin
         cycle();
         total++;
         if ({hold_o, update_o, digits_o} !== {m_hold, m_upd, m_snap[23:0]}) begin
            bad++;
            $display("FAIL arst_after i=%0d got=%b/%h exp=%b/%h", i, update_o, digits_o,
                     m_upd, m_snap[23:0]);
         end
      end
   endtask

   task automatic test_blank();
      logic [5:0] exp_b;
      bit seen = 0;
`ifdef DISPLAY_LZB_EN
      exp_b = 6'b111000;
`else
      exp_b = 6'b000000;
`endif
      value_i = 32'h00000A30;
      for (int i = 0; i < 2*TD && !seen; i++) begin
         cycle();
         if (update_o) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL blank_timeout got=no_update exp=update");
      end else if (blank_o !== exp_b || digits_o !== 24'h000A30) begin
         bad++;
         $display("FAIL blank_a30 got=%b/%h exp=%b/000a30", blank_o, digits_o, exp_b);
      end
   endtask

   task automatic test_random();
      int left = 0;
      for (int i = 0; i < 400; i++) begin
         if (left == 0) begin
            hold_key_n = $urandom_range(0, 1);
            left = $urandom_range(1, 8);
         end
         left--;
         value_i = $urandom >> $urandom_range(0, 28);
         cycle();
         total++;
         if ({hold_o, update_o, digits_o, leds_o, blank_o} !==
             {m_hold, m_upd, m_snap[23:0], m_snap[9:0], exp_blank(m_snap)}) begin
            bad++;
            $display("FAIL random c=%0d got=%b/%b/%h/%h/%b exp=%b/%b/%h/%h/%b", m_cyc,
                     hold_o, update_o, digits_o, leds_o, blank_o, m_hold, m_upd,
                     m_snap[23:0], m_snap[9:0], exp_blank(m_snap));
         end
      end
   endtask

   initial begin
      test_reset();
      test_snapshot();
      test_press();
      test_glitch();
      test_second_press();
      test_press_on_tick();
      test_async_reset();
      test_blank();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_snapshot_ctrl.md
Name: display_snapshot_ctrl

Overview:
- Sits between the core's debug register output and the six seven-segment decoders plus LEDs on the DE0-CV board.
- Samples the fast-changing 32-bit core value at a human-readable rate.
- Lets the user freeze the display with a debounced push-button.
- Emits per-digit nibbles, a blank mask and an LED image.

Parameters:
- TICK_DIV, 5000000, clk cycles per snapshot period (10 Hz at 50 MHz); legal range >= 2.
- DEBOUNCE_CYC, 500000, cycles a key level must be stable before it is accepted (10 ms); legal range >= 2.
- NUM_DIGITS, 6, number of displayed hex digits; fixed at 6 in this revision.

Ports:
- clk  input  1  system clock (CLOCK_50 or divided clock).
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  32  live value from core (regs_31).
- hold_key_n  input  1  raw push-button, active-low, asynchronous to clk.
- digits_o  output  24  snapshot[23:0]; nibble i drives HEXi.
- blank_o  output  6  1 = digit i is to be blanked.
- leds_o  output  10  snapshot[9:0].
- hold_o  output  1  1 while the display is frozen.
- update_o  output  1  one-cycle pulse when a new snapshot becomes visible.

Behaviour:
- Reset (async assert, sync deassert by the board): snapshot=0, digits_o=0, leds_o=0, hold_o=0, update_o=0, tick counter=0, debounce counter=0, debounced key=1 (released), state=RUN.
- Reset mid-operation aborts any debounce or tick in progress; no pulse is emitted.
- Key synchroniser: 2-flop synchroniser on hold_key_n, giving key_s.
- Debounce:
  - If key_s equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1 while still differing, the debounced level takes key_s and the counter clears.
  - A press is a 1->0 transition of the debounced level: a single-cycle internal event. Release produces no event.
- Tick counter:
  - Free-runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - Runs in both states.
- FSM states RUN and HOLD:
  - RUN --press--> HOLD; HOLD --press--> RUN. No other transitions.
- Snapshot:
  - On tick while state==RUN (current-cycle state), snapshot <= value_i.
  - update_o=1 in the following cycle, which is the first cycle the new value is visible. Latency from the tick edge is 1 cycle.
  - update_o pulses even if the new value equals the old one.
- Simultaneous press and tick in RUN: the snapshot is taken, then the state becomes HOLD.
- Simultaneous press and tick in HOLD: no snapshot; the state becomes RUN; the next sample is at the next tick.
- In HOLD, snapshot, digits_o and leds_o are frozen and update_o stays 0.
- hold_o = (state==HOLD), registered (it is the state flop).
- digits_o = snapshot[23:0] and leds_o = snapshot[9:0], driven directly from the snapshot register. snapshot[31:24] is stored but not displayed.
- blank_o is combinational from the snapshot register; it is 6'b000000 unless LZB_EN is defined.

Optional Feature:
- Macro: DISPLAY_LZB_EN.
- Defined: leading-zero blanking. blank_o[i]=1 for i in 1..5 iff nibbles i..5 of snapshot[23:0] are all zero. blank_o[0] is always 0.
  - Snapshot 0 gives 6'b111110.
  - Snapshot 0x000A30 gives 6'b111000.
- Undefined: blank_o=6'b000000 constant.

Decomposition:
- Package display_pkg holds:
  - typedef enum logic {DISP_RUN, DISP_HOLD} disp_state_t.
  - localparam NUM_DIGITS=6.
  - Default TICK_DIV and DEBOUNCE_CYC constants.
- One sub-module, key_debounce: contains the synchroniser, the debounce counter and the press-pulse output. It is reusable for the other KEY inputs.
- The top contains the tick counter, FSM, snapshot register and blank logic.

Test Plan (TICK_DIV=4, DEBOUNCE_CYC=3):
- Reset, then value_i=0x00123456 held: the first tick at cycle 3 after reset release gives digits_o=0x123456 and leds_o=0x056 from cycle 4; update_o is high only in cycle 4 and repeats every 4 cycles.
- Press with hold_key_n low for 10 cycles: hold_o rises once (sync 2 + debounce 3 cycles). value_i then changes to 0xFFFFFFFF: digits_o stays 0x123456 and update_o stays 0.
- Glitch with hold_key_n low for 2 cycles, then high: hold_o stays unchanged and no press event occurs.
- Second stable press: hold_o=0; the next tick loads 0xFFFFFF into digits_o and update_o pulses.
- Press whose debounced edge lands on a tick cycle in RUN: that tick's value_i is captured and hold_o=1 the following cycle.
- rst_n pulsed low mid-HOLD, asynchronously between edges: all outputs return to 0 immediately and state=RUN.
- With DISPLAY_LZB_EN, snapshot 0x000A30 gives blank_o=6'b111000.
